ram_responder: RTL and testbench

Memory-side responder for the CPU's single-port RAM bus (`we`/`addr`/write-data/read-data). It holds a word-addressed memory array and answers CPU reads with a registered, fixed one-cycle latency. It includes a boot-load state machine that fills memory from a streaming valid/ready port while holding the CPU in reset, then hands the bus to the CPU. It sits beside `riscv_cpu` in the top level, which drives the CPU's `reset` from `cpu_reset_o`.

---
 rtl/ram_responder.sv | 118 +++++++++++
 tb/tb_ram_responder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_responder.sv
// Memory-side responder for the CPU RAM bus: word-addressed array with a
// registered one-cycle read, plus a boot loader that fills memory while holding the CPU in reset.
module ram_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter bit          BOOT_LOAD   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    input  logic        load_valid_i,
    input  logic [31:0] load_data_i,
    input  logic        load_last_i,
    output logic        load_ready_o,
    output logic        cpu_reset_o,
    output logic        err_o
);

    localparam int unsigned     AW      = $clog2(DEPTH_WORDS);
    localparam logic [AW-1:0]   PTR_MAX = AW'(DEPTH_WORDS - 1);

    typedef enum logic {
        ST_LOAD,
        ST_RUN
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [31:0]   data_q, data_d;
    logic          err_q, err_d;
    logic          cpu_reset_q, cpu_reset_d;

    logic [31:0]   mem [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic          oor;
    logic          misaligned;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;

    always_comb begin
        idx        = addr_i[AW+1:2];
        oor        = (addr_i >> (AW + 2)) != '0;
        misaligned = addr_i[1:0] != 2'b00;
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        data_d      = '0;
        err_d       = err_q;
        cpu_reset_d = (state_q == ST_LOAD);
        mem_we      = 1'b0;
        mem_waddr   = ptr_q;
        mem_wdata   = load_data_i;

        case (state_q)
            ST_LOAD: begin
                if (load_valid_i) begin
                    mem_we = 1'b1;
                    // Pointer saturates at the last word; that accept also ends the load.
                    if (ptr_q != PTR_MAX) begin
                        ptr_d = ptr_q + AW'(1);
                    end
                    if (load_last_i || ptr_q == PTR_MAX) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                err_d = err_q | oor | misaligned;
                if (!oor) begin
                    if (we_i) begin
                        mem_we    = 1'b1;
                        mem_waddr = idx;
                        mem_wdata = data_i;
                        data_d    = data_i;
                    end else begin
                        data_d = mem[idx];
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= BOOT_LOAD ? ST_LOAD : ST_RUN;
            ptr_q       <= '0;
            data_q      <= '0;
            err_q       <= 1'b0;
            cpu_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            data_q      <= data_d;
            err_q       <= err_d;
            cpu_reset_q <= cpu_reset_d;
        end
    end

    // Memory has no reset; writes are simply suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign data_o       = data_q;
    assign err_o        = err_q;
    assign cpu_reset_o  = cpu_reset_q;
    assign load_ready_o = (state_q == ST_LOAD);

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: a BOOT_LOAD=1 instance (1024 words)
// and a BOOT_LOAD=0 instance (16 words) sharing one clock.
module tb_ram_responder;

    logic        clk = 1'b0;
    int          checks = 0;
    int          errors = 0;

    logic        reset = 1'b1, we = 1'b0, load_valid = 1'b0, load_last = 1'b0;
    logic [31:0] addr = '0, wdata = '0, load_data = '0;
    logic [31:0] rdata;
    logic        load_ready, cpu_reset, err;

    logic        b_reset = 1'b1, b_we = 1'b0, b_load_valid = 1'b0, b_load_last = 1'b0;
    logic [31:0] b_addr = '0, b_wdata = '0, b_load_data = '0;
    logic [31:0] b_rdata;
    logic        b_load_ready, b_cpu_reset, b_err;

    ram_responder #(.DEPTH_WORDS(1024), .BOOT_LOAD(1'b1)) dut (
        .clk(clk), .reset(reset), .we_i(we), .addr_i(addr), .data_i(wdata),
        .data_o(rdata), .load_valid_i(load_valid), .load_data_i(load_data),
        .load_last_i(load_last), .load_ready_o(load_ready),
        .cpu_reset_o(cpu_reset), .err_o(err)
    );

    ram_responder #(.DEPTH_WORDS(16), .BOOT_LOAD(1'b0)) dut_b (
        .clk(clk), .reset(b_reset), .we_i(b_we), .addr_i(b_addr), .data_i(b_wdata),
        .data_o(b_rdata), .load_valid_i(b_load_valid), .load_data_i(b_load_data),
        .load_last_i(b_load_last), .load_ready_o(b_load_ready),
        .cpu_reset_o(b_cpu_reset), .err_o(b_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        we   = 1'b0;
        tick();
        checks++;
        if (rdata !== exp) begin
            errors++;
            $display("FAIL %s: data_o=%08h expected %08h", name, rdata, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks += 4;
        if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: %b expected 1", load_ready); end
        if (cpu_reset !== 1'b1)  begin errors++; $display("FAIL reset_cpu_reset: %b expected 1", cpu_reset); end
        if (rdata !== 32'h0)     begin errors++; $display("FAIL reset_data: %08h expected 0", rdata); end
        if (err !== 1'b0)        begin errors++; $display("FAIL reset_err: %b expected 0", err); end
        reset = 1'b0;
    endtask

    task automatic test_boot_fetch();
        logic [31:0] words [3];
        words[0] = 32'h0000_0013;
        words[1] = 32'h0010_0093;
        words[2] = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_data  = words[i];
            load_last  = (i == 2);
            addr       = 32'h0000_1000;
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        addr       = '0;
        checks += 3;
        if (load_ready !== 1'b0) begin errors++; $display("FAIL boot_ready_drop: %b expected 0", load_ready); end
        if (cpu_reset !== 1'b1)  begin errors++; $display("FAIL boot_cpu_reset_hold: %b expected 1", cpu_reset); end
        if (err !== 1'b0)        begin errors++; $display("FAIL boot_err_in_load: %b expected 0", err); end
        tick();
        checks++;
        if (cpu_reset !== 1'b0) begin errors++; $display("FAIL boot_cpu_reset_fall: %b expected 0", cpu_reset); end
        read_check("fetch0", 32'h0, 32'h0000_0013);
        read_check("fetch4", 32'h4, 32'h0010_0093);
        read_check("fetch8", 32'h8, 32'hDEAD_BEEF);
    endtask

    task automatic test_write_first();
        we    = 1'b1;
        addr  = 32'h10;
        wdata = 32'hA5A5_A5A5;
        tick();
        we = 1'b0;
        checks++;
        if (rdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL write_first: %08h expected a5a5a5a5", rdata); end
        read_check("wf_other", 32'h0, 32'h0000_0013);
        read_check("wf_reread", 32'h10, 32'hA5A5_A5A5);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL wf_err: %b expected 0", err); end
    endtask

    task automatic test_range();
        read_check("oor_read", 32'h0000_1000, 32'h0);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL oor_err: %b expected 1", err); end
        // Dropped write whose low bits alias word 8
        we = 1'b1; addr = 32'h0000_1020; wdata = 32'h0BAD_0BAD;
        tick();
        checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL oor_write_data: %08h expected 0", rdata); end
        read_check("oor_write_dropped", 32'h8, 32'hDEAD_BEEF);
        we = 1'b1; addr = 32'h6; wdata = 32'h1234_5678;
        tick();
        we = 1'b0;
        read_check("misaligned_write", 32'h4, 32'h1234_5678);
        tick();
        tick();
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: %b expected 1", err); end
    endtask

    task automatic test_reset_midload();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL midload_err_clear: %b expected 0", err); end
        for (int i = 0; i < 5; i++) begin
            load_valid = 1'b1;
            load_data  = 32'h1111_0000 + 32'(i);
            tick();
        end
        load_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (cpu_reset !== 1'b1) begin errors++; $display("FAIL midload_cpu_reset_%0d: %b expected 1", i, cpu_reset); end
            load_valid = 1'b1;
            load_data  = 32'h2222_0000 + 32'(i);
            load_last  = (i == 1);
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        checks++;
        if (cpu_reset !== 1'b1) begin errors++; $display("FAIL midload_cpu_reset_hold: %b expected 1", cpu_reset); end
        tick();
        checks++;
        if (cpu_reset !== 1'b0) begin errors++; $display("FAIL midload_cpu_reset_fall: %b expected 0", cpu_reset); end
        read_check("midload_w0", 32'h0,  32'h2222_0000);
        read_check("midload_w1", 32'h4,  32'h2222_0001);
        read_check("midload_w2", 32'h8,  32'h1111_0002);
        read_check("midload_w3", 32'hC,  32'h1111_0003);
        read_check("midload_w4", 32'h10, 32'h1111_0004);
    endtask

    task automatic test_full_boot();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            load_valid = 1'b1;
            load_last  = 1'b0;
            load_data  = 32'hC000_0000 + 32'(i);
            tick();
            if (i == 1022 || i == 1023) begin
                checks++;
                if (load_ready !== (i == 1022)) begin
                    errors++;
                    $display("FAIL full_ready_%0d: %b expected %b", i, load_ready, (i == 1022));
                end
            end
        end
        // Extra valid words after the load must be ignored
        load_data = 32'hFFFF_FFFF;
        tick();
        tick();
        load_valid = 1'b0;
        checks++;
        if (load_ready !== 1'b0) begin errors++; $display("FAIL full_ready_after: %b expected 0", load_ready); end
        read_check("full_w0",    32'h0,   32'hC000_0000);
        read_check("full_w1",    32'h4,   32'hC000_0001);
        read_check("full_wlast", 32'hFFC, 32'hC000_03FF);
    endtask

    task automatic test_boot0();
        b_load_valid = 1'b1;
        b_load_data  = 32'h7777_7777;
        b_reset = 1'b1;
        tick();
        checks += 2;
        if (b_load_ready !== 1'b0) begin errors++; $display("FAIL b0_ready_reset: %b expected 0", b_load_ready); end
        if (b_cpu_reset !== 1'b1)  begin errors++; $display("FAIL b0_cpu_reset_in_reset: %b expected 1", b_cpu_reset); end
        b_reset = 1'b0;
        b_we = 1'b1; b_addr = 32'h8; b_wdata = 32'h0000_55AA;
        tick();
        b_we = 1'b0;
        checks += 3;
        if (b_cpu_reset !== 1'b0)     begin errors++; $display("FAIL b0_cpu_reset_fall: %b expected 0", b_cpu_reset); end
        if (b_load_ready !== 1'b0)    begin errors++; $display("FAIL b0_ready_run: %b expected 0", b_load_ready); end
        if (b_rdata !== 32'h0000_55AA) begin errors++; $display("FAIL b0_write_first: %08h expected 000055aa", b_rdata); end
        b_addr = 32'h4;
        tick();
        b_addr = 32'h8;
        tick();
        checks += 2;
        if (b_rdata !== 32'h0000_55AA) begin errors++; $display("FAIL b0_reread: %08h expected 000055aa", b_rdata); end
        if (b_err !== 1'b0)            begin errors++; $display("FAIL b0_err_clean: %b expected 0", b_err); end
        b_addr = 32'h40;
        tick();
        checks += 3;
        if (b_rdata !== 32'h0)     begin errors++; $display("FAIL b0_oor_data: %08h expected 0", b_rdata); end
        if (b_err !== 1'b1)        begin errors++; $display("FAIL b0_oor_err: %b expected 1", b_err); end
        if (b_load_ready !== 1'b0) begin errors++; $display("FAIL b0_ready_end: %b expected 0", b_load_ready); end
        b_load_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_boot_fetch();
        test_write_first();
        test_range();
        test_reset_midload();
        test_full_boot();
        test_boot0();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
